// File: rtl/icache_axi_refill_pkg.sv
// Shared pipeline types for the ICache refill path: bus widths, AXI burst
// encodings and the refill sequencing states.
package pipeline_types;

  typedef logic [31:0]  bus32_t;
  typedef logic [255:0] bus256_t;

  localparam int         ICACHE_LINE_BEATS = 8;
  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B       = 3'b010;

  typedef enum logic [1:0] {IDLE, AR, R, RET} refill_state_t;

endpackage

// File: rtl/icache_axi_refill_if.sv
// ICache <-> memory refill handshake: the cache requests a line address and
// receives the full 256-bit line with a single-cycle return strobe.
interface icache_mem;
  import pipeline_types::*;

  logic    rd_req;
  bus32_t  rd_addr;
  logic    ret_valid;
  bus256_t ret_data;

  modport master (output rd_req, output rd_addr, input  ret_valid, input  ret_data);
  modport slave  (input  rd_req, input  rd_addr, output ret_valid, output ret_data);

endinterface

// File: rtl/icache_axi_refill.sv
// Turns one ICache line request into a single 8-beat AXI4 INCR read burst and
// returns the assembled line. One refill in flight at a time.
module icache_axi_refill
  import pipeline_types::*;
#(
    parameter logic [3:0] ARID_VAL = 4'd0
) (
    input  logic            clk,
    input  logic            rst,
    icache_mem.slave        icache,
    output logic [3:0]      arid,
    output bus32_t          araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    input  logic [3:0]      rid,
    input  bus32_t          rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic            busy
);

    localparam logic [2:0] LAST_BEAT = 3'(ICACHE_LINE_BEATS - 1);

    refill_state_t state;
    bus32_t        line_addr;
    bus256_t       line_buf;
    logic [2:0]    beat_cnt;

    // Completion is beat-counted with a single ID in flight, so these carry no information.
    logic unused_inputs;
    assign unused_inputs = ^{rid, rresp, rlast, icache.rd_addr[4:0]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            line_addr <= '0;
            // NOTE: the line buffer is a plain register bank, not a RAM, so it
            // is cleared by reset; ret_data must read zero after reset.
            line_buf  <= '0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (icache.rd_req) begin
                        line_addr <= {icache.rd_addr[31:5], 5'b0};
                        beat_cnt  <= '0;
                        state     <= AR;
                    end
                end
                AR: begin
                    if (arready) state <= R;
                end
                R: begin
                    if (rvalid) begin
                        line_buf[{beat_cnt, 5'b0} +: 32] <= rdata;
                        beat_cnt <= beat_cnt + 3'd1;
                        if (beat_cnt == LAST_BEAT) state <= RET;
                    end
                end
                RET:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Every output is a constant, a register, or a decode of state alone.
    assign arid     = ARID_VAL;
    assign arlen    = 8'(ICACHE_LINE_BEATS - 1);
    assign arsize   = AXI_SIZE_4B;
    assign arburst  = AXI_BURST_INCR;
    assign araddr   = line_addr;
    assign arvalid  = (state == AR);
    assign rready   = (state == R);
    assign busy     = (state != IDLE);

    assign icache.ret_valid = (state == RET);
    assign icache.ret_data  = line_buf;

endmodule

// File: tb/tb_icache_axi_refill.sv
// Directed bench for icache_axi_refill: an AXI read responder, a transaction
// level model checked every cycle, and literal expectations per scenario.
module tb_icache_axi_refill;
  import pipeline_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_mem ic ();

  logic [3:0] arid;
  bus32_t     araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic       arvalid;
  logic       arready = 1'b0;
  logic [3:0] rid = 4'd5;
  bus32_t     rdata = '0;
  logic [1:0] rresp = 2'b10;
  logic       rlast = 1'b0;
  logic       rvalid = 1'b0;
  logic       rready;
  logic       busy;

  icache_axi_refill #(.ARID_VAL(4'd0)) dut (
    .clk(clk), .rst(rst), .icache(ic),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- AXI read responder ----------------
  bus32_t beat_data [8];
  int     ar_stall = 0;
  bit     gap_en = 1'b0;
  int     ar_left, beat_idx, gap_left;
  logic   ar_prev = 1'b0, rready_last = 1'b0;

  always @(negedge clk) begin
    if (rvalid && rready_last) begin
      beat_idx++;
      gap_left = gap_en ? int'($urandom_range(0, 3)) : 0;
    end
    if (arvalid) begin
      if (!ar_prev) begin
        ar_left  = ar_stall;
        beat_idx = 0;
        gap_left = gap_en ? int'($urandom_range(0, 3)) : 0;
      end
      arready = (ar_left == 0);
      if (ar_left > 0) ar_left--;
    end else begin
      arready = 1'b0;
    end
    if (rready) begin
      if (gap_left > 0) begin
        rvalid = 1'b0;
        gap_left--;
      end else begin
        rvalid = 1'b1;
        rdata  = beat_data[beat_idx % 8];
      end
    end else begin
      rvalid = 1'b0;
    end
    ar_prev     = arvalid;
    rready_last = rready;
  end

  // ---------------- transaction-level model ----------------
  // Tracks a refill by its progress: requested, address accepted, beats
  // collected, line returned. Outputs follow from that progress.
  bit      m_live = 1'b0;
  bit      m_active, m_ar_done, m_ret;
  bus32_t  m_addr;
  bus256_t m_line;
  bus32_t  m_beats[$];

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1'b1; m_active = 1'b0; m_ar_done = 1'b0; m_ret = 1'b0;
      m_addr = '0; m_line = '0; m_beats.delete();
    end else if (m_live) begin
      if (m_ret) begin
        m_ret = 1'b0;
        m_active = 1'b0;
      end else if (!m_active) begin
        if (ic.rd_req) begin
          m_active = 1'b1; m_ar_done = 1'b0; m_beats.delete();
          m_addr = ic.rd_addr & ~32'h1F;
        end
      end else if (!m_ar_done) begin
        m_ar_done = arready;
      end else if (rvalid) begin
        m_beats.push_back(rdata);
        if (m_beats.size() == 8) begin
          for (int i = 0; i < 8; i++) m_line[i*32 +: 32] = m_beats[i];
          m_ret = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("arvalid", arvalid, m_active && !m_ar_done);
      check("rready", rready, m_active && m_ar_done && !m_ret);
      check("ret_valid", ic.ret_valid, m_ret);
      check("busy", busy, m_active);
      if (m_active && !m_ar_done) begin
        check("araddr", araddr, m_addr);
        check("ar_consts", {arid, arlen, arsize, arburst}, {4'd0, 8'd7, 3'b010, 2'b01});
      end
      if (m_ret) check("ret_data", ic.ret_data, m_line);
    end
  end

  // ---------------- scenarios ----------------
  task automatic run_refill(input bus32_t addr, input bus32_t exp_araddr, input int stall,
                            output int lat, output int pulses, output bus256_t line);
    lat = -1; pulses = 0; line = '0;
    ar_stall = stall;
    ic.rd_req = 1'b1; ic.rd_addr = addr;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) ic.rd_req = 1'b0;
      if (k == 2) ic.rd_addr = 32'hDEAD_BEE0;
      if (k <= stall + 1) begin
        check("ar_hold_arvalid", arvalid, 1'b1);
        check("ar_hold_rready", rready, 1'b0);
        check("ar_hold_araddr", araddr, exp_araddr);
      end
      if (ic.ret_valid) begin
        pulses++;
        if (lat < 0) begin lat = k; line = ic.ret_data; end
      end
      if (lat >= 0 && k >= lat + 3) break;
    end
  endtask

  int      lat, pulses;
  bus256_t line, exp_line;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ic.rd_req = 1'b0; ic.rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_ret_valid", ic.ret_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_ret_data", ic.ret_data, 256'h0);
    rst = 1'b0;
    @(negedge clk);

    // Basic refill, zero wait states.
    for (int i = 0; i < 8; i++) beat_data[i] = 32'h1111_1111 * (i + 1);
    run_refill(32'h1C00_0014, 32'h1C00_0000, 0, lat, pulses, line);
    check("basic_latency", lat, 10);
    check("basic_pulses", pulses, 1);
    check("basic_word0", line[31:0], 32'h1111_1111);
    check("basic_word7", line[255:224], 32'h8888_8888);

    // AR backpressure, address change during the stall.
    for (int i = 0; i < 8; i++) beat_data[i] = 32'h5000_0000 + i;
    run_refill(32'h0000_ABCD, 32'h0000_ABC0, 5, lat, pulses, line);
    check("bp_latency", lat, 15);
    check("bp_pulses", pulses, 1);
    check("bp_word3", line[127:96], 32'h5000_0003);

    // R-channel gaps.
    gap_en = 1'b1;
    for (int i = 0; i < 8; i++) beat_data[i] = 32'hA0A0_0000 | (i << 4);
    run_refill(32'h8000_0040, 32'h8000_0040, 0, lat, pulses, line);
    for (int i = 0; i < 8; i++) exp_line[i*32 +: 32] = 32'hA0A0_0000 | (i << 4);
    check("gap_line", line, exp_line);
    check("gap_pulses", pulses, 1);
    check("gap_latency_min", lat >= 10, 1'b1);
    gap_en = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back: rd_req held through ret_valid.
    ar_stall = 0;
    for (int i = 0; i < 8; i++) beat_data[i] = 32'hB000_0000 + i;
    ic.rd_req = 1'b1; ic.rd_addr = 32'h0000_4020;
    lat = -1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 10) begin
        check("b2b_first_ret", ic.ret_valid, 1'b1);
        ic.rd_addr = 32'h0000_8044;
      end
      if (k == 11) begin
        check("b2b_idle_busy", busy, 1'b0);
        check("b2b_idle_arvalid", arvalid, 1'b0);
      end
      if (k == 12) begin
        check("b2b_second_ar", arvalid, 1'b1);
        check("b2b_second_addr", araddr, 32'h0000_8040);
        ic.rd_req = 1'b0;
      end
      if (k > 12 && ic.ret_valid && lat < 0) lat = k;
      if (lat >= 0) break;
    end
    check("b2b_second_latency", lat, 21);
    repeat (2) @(negedge clk);

    // Reset after beat 3.
    for (int i = 0; i < 8; i++) beat_data[i] = 32'hC000_0000 + i;
    ic.rd_req = 1'b1; ic.rd_addr = 32'h0000_1000;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) ic.rd_req = 1'b0;
      if (k == 5) rst = 1'b1;
      if (k == 6) begin
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rready", rready, 1'b0);
        check("mid_rst_ret_valid", ic.ret_valid, 1'b0);
        check("mid_rst_ret_data", ic.ret_data, 256'h0);
        check("mid_rst_araddr", araddr, 32'h0);
        rst = 1'b0;
      end
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) beat_data[i] = 32'hD000_0000 + (i * 3);
    run_refill(32'h0000_2004, 32'h0000_2000, 0, lat, pulses, line);
    for (int i = 0; i < 8; i++) exp_line[i*32 +: 32] = 32'hD000_0000 + (i * 3);
    check("post_rst_latency", lat, 10);
    check("post_rst_line", line, exp_line);
    check("post_rst_pulses", pulses, 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
